if_fetch_unit: RTL and testbench

Instruction-fetch front end for the IF stage. Holds the fetch PC, queries the branch predictor with it and selects the next PC (predicted target or PC+4). Issues one-outstanding requests to instruction memory and buffers fetched instructions, with their prediction tags, in a small FIFO toward ID. Applies the flush redirect that ID raises through the predictor on a misprediction.

---
 rtl/if_fetch_unit_pkg.sv | 31 +++
 rtl/if_fetch_unit_if.sv | 39 +++
 rtl/if_fetch_fifo.sv | 75 +++++++
 rtl/if_fetch_unit.sv | 120 ++++++++++++
 tb/tb_if_fetch_unit.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared types for the IF fetch front end: register width, reset PC, FSM states, entries.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_fetch_unit_pkg;

  localparam int RegW = 32;
  localparam logic [RegW-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // Fetch FSM: REQ issues, WAIT expects a response to keep, DROP expects one to discard.
  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  // Buffered instruction toward ID, 97 bits.
  typedef struct packed {
    logic [RegW-1:0] pc;
    logic [RegW-1:0] inst;
    logic            pred_taken;
    logic [RegW-1:0] pred_target;
  } fetch_entry_t;

  // Snapshot of the outstanding request, taken at grant.
  typedef struct packed {
    logic [RegW-1:0] pc;
    logic            pred_taken;
    logic [RegW-1:0] pred_target;
  } fetch_pend_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bundles the predictor, instruction-memory and ID-side signals of the fetch unit.
// Latency: n/a (wiring only).
// Backpressure: carried by inst_gnt_i (memory side) and id_ready_i (ID side).
// Ports: master = fetch unit view (_o driven, _i sampled); slave = environment view.
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  logic [RegW-1:0] if_predict_pc_o;
  logic            if_predict_taken_i;
  logic [RegW-1:0] if_predict_targetPc_i;
  logic            if_predict_failed_i;
  logic [RegW-1:0] if_flush_pc_i;
  logic            inst_req_o;
  logic [RegW-1:0] inst_addr_o;
  logic            inst_gnt_i;
  logic            inst_rvalid_i;
  logic [RegW-1:0] inst_rdata_i;
  logic            id_valid_o;
  logic            id_ready_i;
  logic [RegW-1:0] id_pc_o;
  logic [RegW-1:0] id_inst_o;
  logic            id_predTaken_o;
  logic [RegW-1:0] id_predTargetPc_o;

  modport master (
    output if_predict_pc_o, inst_req_o, inst_addr_o,
           id_valid_o, id_pc_o, id_inst_o, id_predTaken_o, id_predTargetPc_o,
    input  if_predict_taken_i, if_predict_targetPc_i, if_predict_failed_i, if_flush_pc_i,
           inst_gnt_i, inst_rvalid_i, inst_rdata_i, id_ready_i
  );

  modport slave (
    input  if_predict_pc_o, inst_req_o, inst_addr_o,
           id_valid_o, id_pc_o, id_inst_o, id_predTaken_o, id_predTargetPc_o,
    output if_predict_taken_i, if_predict_targetPc_i, if_predict_failed_i, if_flush_pc_i,
           inst_gnt_i, inst_rvalid_i, inst_rdata_i, id_ready_i
  );

endinterface

// File: rtl/if_fetch_fifo.sv
// Synchronous FIFO of fetched instructions with a clear that voids same-cycle push/pop.
// Latency: 1 cycle push-to-head.
// Backpressure: push ignored when full unless a pop frees the slot in the same cycle.
// Ports: clk_i/rst_i, clr_i, push_i/push_dat_i, pop_i, head_o, full_o, empty_o, count_o.
module if_fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_dat_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    full_o   = (count_q == CW'(DEPTH));
    empty_o  = (count_q == '0);
    pop_ok   = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    push_ok  = push_i & (~full_o | pop_ok);
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_dat_i;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// IF front end: fetch PC + next-PC select, one-outstanding imem requests, FIFO toward ID, flush redirect.
// Latency: grant to id_valid_o 2 cycles with rvalid one cycle after grant; 1 instruction per 2 cycles.
// Backpressure: no request unless the FIFO has a free slot now; ID stalls via id_ready_i.
// Ports: clk_i, rst_i (async, active-high), bus (if_fetch_unit_if.master: predictor, imem, ID).
// Build option: IF_BRANCH_PREDICT_EN enables use of the predictor's taken/target on grant.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [RegW-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input logic             clk_i,
  input logic             rst_i,
  if_fetch_unit_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [RegW-1:0] pc_q, pc_d;
  fetch_pend_t     pend_q, pend_d;

  logic            req, push, pop, clr;
  logic            pred_taken_s;
  logic [RegW-1:0] pred_target_s;
  fetch_entry_t    push_dat, head;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            unused_fifo_full;

`ifdef IF_BRANCH_PREDICT_EN
  assign pred_taken_s  = bus.if_predict_taken_i;
  assign pred_target_s = bus.if_predict_targetPc_i;
`else
  logic unused_pred;
  assign unused_pred   = ^{bus.if_predict_taken_i, bus.if_predict_targetPc_i};
  assign pred_taken_s  = 1'b0;
  assign pred_target_s = '0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    req     = 1'b0;
    push    = 1'b0;
    clr     = 1'b0;
    case (state_q)
      FETCH_REQ: begin
        // rst_i gate keeps the request low while reset is held.
        req = (fifo_count < CW'(FIFO_DEPTH)) & ~bus.if_predict_failed_i & ~rst_i;
        if (req && bus.inst_gnt_i) begin
          pend_d  = '{pc: pc_q, pred_taken: pred_taken_s, pred_target: pred_target_s};
          pc_d    = pred_taken_s ? pred_target_s : pc_q + 32'd4;
          state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (bus.inst_rvalid_i) begin
          push    = 1'b1;
          state_d = FETCH_REQ;
        end
      end
      FETCH_DROP: begin
        if (bus.inst_rvalid_i) state_d = FETCH_REQ;
      end
      default: state_d = FETCH_REQ;
    endcase
    pop = bus.id_ready_i & ~fifo_empty;
    // Flush wins everywhere; a response still owed after the flush must be swallowed in DROP.
    if (bus.if_predict_failed_i) begin
      pc_d    = bus.if_flush_pc_i;
      clr     = 1'b1;
      push    = 1'b0;
      pop     = 1'b0;
      state_d = (state_q == FETCH_REQ || bus.inst_rvalid_i) ? FETCH_REQ : FETCH_DROP;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FETCH_REQ;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  assign push_dat = '{pc: pend_q.pc, inst: bus.inst_rdata_i,
                      pred_taken: pend_q.pred_taken, pred_target: pend_q.pred_target};

  if_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (clr),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign unused_fifo_full = fifo_full;

  assign bus.if_predict_pc_o   = pc_q;
  assign bus.inst_addr_o       = pc_q;
  assign bus.inst_req_o        = req;
  // Head data is forced to zero while the buffer is empty.
  assign bus.id_valid_o        = ~fifo_empty;
  assign bus.id_pc_o           = fifo_empty ? '0 : head.pc;
  assign bus.id_inst_o         = fifo_empty ? '0 : head.inst;
  assign bus.id_predTaken_o    = fifo_empty ? 1'b0 : head.pred_taken;
  assign bus.id_predTargetPc_o = fifo_empty ? '0 : head.pred_target;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: per-cycle vector table plus a streaming in-order sequence.
// Latency: n/a.
// Backpressure: exercised through id_ready_i and inst_gnt_i stimulus.
module tb_if_fetch_unit;

`ifdef IF_BRANCH_PREDICT_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam logic [31:0] A   = PE ? 32'h8000_0100 : 32'h8000_000C;
  localparam logic [31:0] T   = PE ? 32'h8000_0100 : 32'h0000_0000;
  localparam logic [31:0] I0 = 32'h1111_0013, I1 = 32'h2222_0013, I2 = 32'h3333_0013;
  localparam logic [31:0] I3 = 32'h4444_0013, I4 = 32'h5555_0013, I5 = 32'h6666_0013;
  localparam logic [31:0] I6 = 32'h7777_0013, I7 = 32'h8888_0013, I8 = 32'h9999_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_unit_if bus_if ();

  if_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  typedef struct {
    bit rst, rdy, gnt, rv;
    logic [31:0] rdata;
    bit fail;
    logic [31:0] fpc;
    bit tk;
    logic [31:0] tgt;
    bit e_req;
    logic [31:0] e_addr;
    bit e_vld;
    logic [31:0] e_pc, e_inst;
    bit e_tk;
    logic [31:0] e_tg;
  } vec_t;

  vec_t vt[$];
  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(bit rst_v, bit rdy, bit gnt, bit rv, logic [31:0] rdata,
                              bit fail, logic [31:0] fpc, bit tk, logic [31:0] tgt,
                              bit e_req, logic [31:0] e_addr, bit e_vld, logic [31:0] e_pc,
                              logic [31:0] e_inst, bit e_tk, logic [31:0] e_tg);
    vec_t v;
    v.rst = rst_v; v.rdy = rdy; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.fail = fail; v.fpc = fpc; v.tk = tk; v.tgt = tgt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc;
    v.e_inst = e_inst; v.e_tk = e_tk; v.e_tg = e_tg;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    bit          pend_rsp;
    logic [31:0] pend_addr;
    logic [31:0] exp_pc;
    int          popped;

    bus_if.if_predict_taken_i    = 1'b0;
    bus_if.if_predict_targetPc_i = '0;
    bus_if.if_predict_failed_i   = 1'b0;
    bus_if.if_flush_pc_i         = '0;
    bus_if.inst_gnt_i            = 1'b0;
    bus_if.inst_rvalid_i         = 1'b0;
    bus_if.inst_rdata_i          = '0;
    bus_if.id_ready_i            = 1'b0;

    //               rst rdy gnt rv rdata        fail fpc           tk tgt            | req addr  vld pc            inst  tk  tg
    vt.push_back(mk(1, 1, 1, 0, 0,            0, 0,            0, 0,            0, RPC,          0, 0,            0,  0,  0)); // reset
    vt.push_back(mk(0, 1, 1, 0, 0,            0, 0,            0, 0,            1, RPC,          0, 0,            0,  0,  0));
    vt.push_back(mk(0, 1, 1, 1, I0,           0, 0,            0, 0,            0, RPC + 4,      0, 0,            0,  0,  0));
    vt.push_back(mk(0, 1, 1, 0, 0,            0, 0,            0, 0,            1, RPC + 4,      1, RPC,          I0, 0,  0)); // grant->valid 2 cycles
    vt.push_back(mk(0, 1, 1, 1, I1,           0, 0,            0, 0,            0, RPC + 8,      0, 0,            0,  0,  0));
    vt.push_back(mk(0, 1, 1, 0, 0,            0, 0,            1, 32'h8000_0100, 1, RPC + 8,     1, RPC + 4,      I1, 0,  0)); // predicted taken
    vt.push_back(mk(0, 1, 1, 1, I2,           0, 0,            0, 0,            0, A,            0, 0,            0,  0,  0));
    vt.push_back(mk(0, 0, 1, 0, 0,            0, 0,            0, 0,            1, A,            1, RPC + 8,      I2, PE, T)); // ID stalls
    vt.push_back(mk(0, 0, 1, 1, I3,           0, 0,            0, 0,            0, A + 4,        1, RPC + 8,      I2, PE, T));
    for (int k = 0; k < 8; k++)
      vt.push_back(mk(0, 0, 1, 0, 0,          0, 0,            0, 0,            0, A + 4,        1, RPC + 8,      I2, PE, T)); // full: no req
    vt.push_back(mk(0, 1, 1, 0, 0,            0, 0,            0, 0,            0, A + 4,        1, RPC + 8,      I2, PE, T)); // drain
    vt.push_back(mk(0, 1, 1, 0, 0,            0, 0,            0, 0,            1, A + 4,        1, A,            I3, 0,  0));
    vt.push_back(mk(0, 1, 1, 1, I4,           0, 0,            0, 0,            0, A + 8,        0, 0,            0,  0,  0));
    vt.push_back(mk(0, 0, 1, 0, 0,            0, 0,            0, 0,            1, A + 8,        1, A + 4,        I4, 0,  0));
    vt.push_back(mk(0, 0, 1, 0, 0,            1, 32'h8000_0200, 0, 0,           0, A + 12,       1, A + 4,        I4, 0,  0)); // flush in WAIT
    vt.push_back(mk(0, 1, 1, 0, 0,            0, 0,            0, 0,            0, 32'h8000_0200, 0, 0,           0,  0,  0));
    vt.push_back(mk(0, 1, 1, 0, 0,            0, 0,            0, 0,            0, 32'h8000_0200, 0, 0,           0,  0,  0));
    vt.push_back(mk(0, 1, 1, 1, 32'hDEAD_BEEF, 0, 0,           0, 0,            0, 32'h8000_0200, 0, 0,           0,  0,  0)); // late rsp dropped
    vt.push_back(mk(0, 1, 1, 0, 0,            0, 0,            0, 0,            1, 32'h8000_0200, 0, 0,           0,  0,  0));
    vt.push_back(mk(0, 1, 1, 1, I5,           0, 0,            0, 0,            0, 32'h8000_0204, 0, 0,           0,  0,  0));
    vt.push_back(mk(0, 0, 1, 0, 0,            0, 0,            0, 0,            1, 32'h8000_0204, 1, 32'h8000_0200, I5, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, I6,           0, 0,            0, 0,            0, 32'h8000_0208, 1, 32'h8000_0200, I5, 0, 0));
    vt.push_back(mk(0, 1, 1, 1, 32'hBAD0_0001, 1, 32'h8000_0300, 0, 0,          0, 32'h8000_0208, 1, 32'h8000_0200, I5, 0, 0)); // flush, full, rv, ready
    vt.push_back(mk(0, 1, 1, 0, 0,            0, 0,            0, 0,            1, 32'h8000_0300, 0, 0,           0,  0,  0));
    vt.push_back(mk(0, 1, 1, 1, 32'hBAD0_0002, 1, 32'h8000_0400, 0, 0,          0, 32'h8000_0304, 0, 0,           0,  0,  0)); // flush with rv in WAIT
    vt.push_back(mk(0, 1, 1, 0, 0,            0, 0,            0, 0,            1, 32'h8000_0400, 0, 0,           0,  0,  0));
    vt.push_back(mk(0, 1, 1, 1, I7,           0, 0,            0, 0,            0, 32'h8000_0404, 0, 0,           0,  0,  0));
    vt.push_back(mk(0, 1, 1, 0, 0,            1, 32'h8000_0500, 0, 0,           0, 32'h8000_0404, 1, 32'h8000_0400, I7, 0, 0)); // flush in REQ
    vt.push_back(mk(0, 1, 1, 0, 0,            0, 0,            0, 0,            1, 32'h8000_0500, 0, 0,           0,  0,  0));
    vt.push_back(mk(1, 1, 1, 0, 0,            0, 0,            0, 0,            0, RPC,          0, 0,            0,  0,  0)); // reset mid-WAIT
    vt.push_back(mk(0, 1, 0, 1, 32'h1A7E_0000, 0, 0,           0, 0,            1, RPC,          0, 0,            0,  0,  0)); // late rvalid
    vt.push_back(mk(0, 1, 0, 0, 0,            0, 0,            0, 0,            1, RPC,          0, 0,            0,  0,  0));
    vt.push_back(mk(0, 1, 1, 0, 0,            1, 32'hFFFF_FFFE, 0, 0,           0, RPC,          0, 0,            0,  0,  0));
    vt.push_back(mk(0, 1, 1, 0, 0,            0, 0,            0, 0,            1, 32'hFFFF_FFFE, 0, 0,           0,  0,  0)); // wraps
    vt.push_back(mk(0, 1, 1, 1, I8,           0, 0,            0, 0,            0, 32'h0000_0002, 0, 0,           0,  0,  0));
    vt.push_back(mk(0, 1, 1, 0, 0,            0, 0,            0, 0,            1, 32'h0000_0002, 1, 32'hFFFF_FFFE, I8, 0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      rst                          = vt[i].rst;
      bus_if.id_ready_i            = vt[i].rdy;
      bus_if.inst_gnt_i            = vt[i].gnt;
      bus_if.inst_rvalid_i         = vt[i].rv;
      bus_if.inst_rdata_i          = vt[i].rdata;
      bus_if.if_predict_failed_i   = vt[i].fail;
      bus_if.if_flush_pc_i         = vt[i].fpc;
      bus_if.if_predict_taken_i    = vt[i].tk;
      bus_if.if_predict_targetPc_i = vt[i].tgt;
      #1;
      check($sformatf("v%0d req", i), bus_if.inst_req_o, vt[i].e_req);
      check($sformatf("v%0d addr", i), bus_if.inst_addr_o, vt[i].e_addr);
      check($sformatf("v%0d pred_pc", i), bus_if.if_predict_pc_o, vt[i].e_addr);
      check($sformatf("v%0d id_valid", i), bus_if.id_valid_o, vt[i].e_vld);
      if (vt[i].e_vld || vt[i].rst) begin
        check($sformatf("v%0d id_pc", i), bus_if.id_pc_o, vt[i].e_pc);
        check($sformatf("v%0d id_inst", i), bus_if.id_inst_o, vt[i].e_inst);
        check($sformatf("v%0d id_tk", i), bus_if.id_predTaken_o, vt[i].e_tk);
        check($sformatf("v%0d id_tgt", i), bus_if.id_predTargetPc_o, vt[i].e_tg);
      end
    end

    // Streaming: responder answers one cycle after each grant, ID ready random.
    @(negedge clk);
    bus_if.inst_gnt_i          = 1'b0;
    bus_if.inst_rvalid_i       = 1'b0;
    bus_if.if_predict_failed_i = 1'b0;
    bus_if.if_predict_taken_i  = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    pend_rsp  = 1'b0;
    pend_addr = '0;
    exp_pc    = RPC;
    popped    = 0;
    for (int cyc = 0; cyc < 200 && popped < 6; cyc++) begin
      @(negedge clk);
      bus_if.inst_gnt_i    = 1'b1;
      bus_if.inst_rvalid_i = pend_rsp;
      bus_if.inst_rdata_i  = pend_addr ^ 32'h5A5A_0000;
      bus_if.id_ready_i    = 1'($urandom_range(0, 1));
      #1;
      pend_rsp = bus_if.inst_req_o;
      if (pend_rsp) pend_addr = bus_if.inst_addr_o;
      if (bus_if.id_valid_o && bus_if.id_ready_i) begin
        check($sformatf("stream%0d pc", popped), bus_if.id_pc_o, exp_pc);
        check($sformatf("stream%0d inst", popped), bus_if.id_inst_o, exp_pc ^ 32'h5A5A_0000);
        exp_pc += 32'd4;
        popped++;
      end
    end
    checks++;
    if (popped < 6) begin
      errors++;
      $display("FAIL stream timeout: got %0d pops expected 6", popped);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
